ttl_pulse_tx: RTL
=================

Name: ttl_pulse_tx

Overview:
Transmit end of the single-ended TTL pulse link. The existing pulse-width receiver measures the high time of an incoming TTL pulse; this block generates such pulses.
- On a command it drives a train of COUNT pulses, each WIDTH clk cycles high and GAP_CYCLES low.
- Sits between control logic and a board output pin (e.g. B16_L22_P) on the 100 MHz clk_wiz_0 clock domain.

Parameters:
CNT_W, 32, width of the pulse-width field and the internal high/low counters
REP_W, 8, width of the repeat-count field
GAP_CYCLES, 100, low cycles after every pulse (1 us at 100 MHz); must be >= 1

Ports:
clk  input  1  system clock (100 MHz from clk_wiz_0)
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_width  input  CNT_W  high time per pulse, in clk cycles
cmd_count  input  REP_W  number of pulses in the train
pulse_out  output  1  registered TTL pulse output
busy  output  1  high while a train is in progress, including its gaps
done  output  1  one-cycle strobe when a train completes

Behaviour:
- Reset: all of the following on the clk edge with rst=1, with in-progress trains discarded:
  - pulse_out=0, busy=0, done=0, cmd_ready=0 while rst is high.
  - State=IDLE, all counters cleared.
  - cmd_ready=1 from the first cycle after rst drops.
- Handshake: a command is accepted at an edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) && !rst. It is combinational from state only, never from cmd_valid.
  - cmd_width and cmd_count are latched at acceptance. Later changes on the inputs are ignored.
- States: IDLE, HIGH, LOW, FIN.
  - IDLE -> HIGH on accept, when width!=0 and count!=0.
  - IDLE -> FIN on accept, when width==0 or count==0. No pulse is emitted.
  - HIGH lasts exactly width cycles, then -> LOW.
  - LOW lasts exactly GAP_CYCLES cycles. It then goes -> HIGH if pulses remain, else -> FIN.
  - FIN lasts 1 cycle, then -> IDLE.
- Timing: with acceptance at edge k:
  - pulse_out=1 for cycles k+1 .. k+width.
  - Period per pulse = width+GAP_CYCLES.
  - Total train length = count*(width+GAP_CYCLES) cycles, then 1 FIN cycle.
- Outputs per state:
  - busy=1 in HIGH, LOW and FIN.
  - done=1 only in FIN.
  - cmd_ready returns to 1 in the cycle after FIN.
- Width rules:
  - Maximum width is 2^CNT_W-1 with no wrap.
  - A high counter loads width-1 and counts down to 0. The low counter does the same with GAP_CYCLES-1.
  - The remaining-pulse counter is REP_W bits and decrements at each HIGH->LOW transition.
- Simultaneous events: a cmd_valid held through a train is not accepted until IDLE. rst overrides every other input.
- Reset mid-pulse: pulse_out falls at the reset edge and done is not generated.

Optional Feature:
Macro TTL_PULSE_TX_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in HIGH: pulse_out falls on the next edge and the block enters LOW with a full GAP_CYCLES gap. It then goes to FIN regardless of the pulses remaining, and done pulses normally.
  - abort=1 in LOW: the block finishes the current gap, then goes to FIN.
  - abort is ignored in IDLE and FIN.
- Not defined: no abort port, and behaviour is exactly as above.

Decomposition:
- Package ttl_pulse_pkg holds:
  - state enum typedef tx_state_t (IDLE, HIGH, LOW, FIN), 2 bits.
  - localparam DEFAULT_GAP_CYCLES = 100.
  - localparam CLK_HZ = 100_000_000.
- Sub-module: ttl_pulse_down_cnt, a loadable down counter with parameterised width.
  - Ports: clk, rst, load, load_val, en, zero.
  - Instantiated twice: once for the high time, once for the low time.

Test Plan:
- Basic pulse:
  - Stimulus: after reset, cmd_width=5, cmd_count=1 accepted at edge k.
  - Required: pulse_out high for exactly cycles k+1..k+5, low for 100 cycles, done=1 at cycle k+106, cmd_ready=1 at k+107.
- Pulse train:
  - Stimulus: width=3, count=4, GAP_CYCLES=2.
  - Required: 4 pulses of 3 high and 2 low; rising edges 5 cycles apart; busy high for 21 cycles; exactly one done strobe.
- Zero cases:
  - Stimulus: width=0, count=7; then width=10, count=0.
  - Required: each accepted, pulse_out stays 0, done one cycle after acceptance.
- Back-pressure:
  - Stimulus: hold cmd_valid=1 with width=2, count=1 continuously.
  - Required: second accept happens only in the cycle after done; command latched values are unaffected by input changes during the train.
- Reset mid-operation:
  - Stimulus: width=1000, count=1; assert rst at cycle 400 of the pulse.
  - Required: pulse_out=0 and busy=0 from the reset edge, no done, cmd_ready=1 one cycle after rst drops.
- Abort (only with TTL_PULSE_TX_ABORT_EN):
  - Stimulus: width=50, count=3; abort at cycle 10 of the first pulse.
  - Required: pulse_out falls next edge, then 100 low cycles, then done, with no second pulse.

Source files
------------

// File: rtl/ttl_pulse_pkg.sv
// Shared types and constants for the TTL pulse transmitter.
package ttl_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } tx_state_t;

  localparam int unsigned DEFAULT_GAP_CYCLES = 100;
  localparam int unsigned CLK_HZ             = 100_000_000;

  // Bits needed to hold (cycles - 1), never less than one.
  function automatic int unsigned load_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/ttl_pulse_down_cnt.sv
// Loadable down counter that stops at zero; zero flags the terminal count.
module ttl_pulse_down_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/ttl_pulse_tx.sv
// TTL pulse-train transmitter: COUNT pulses of WIDTH high cycles, each followed by GAP_CYCLES low.
// Optional abort input enabled by defining TTL_PULSE_TX_ABORT_EN.
module ttl_pulse_tx
  import ttl_pulse_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned REP_W      = 8,
  parameter int unsigned GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TTL_PULSE_TX_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_width,
  input  logic [REP_W-1:0] cmd_count,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned       GAP_W    = load_width(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [REP_W-1:0] rem_q, rem_d;
  logic             pulse_q, pulse_d;

  logic             hi_load, hi_en, hi_zero;
  logic [CNT_W-1:0] hi_load_val;
  logic             lo_load, lo_en, lo_zero;
  logic             accept;
  logic             abort_req;
  logic             stop_now;

`ifdef TTL_PULSE_TX_ABORT_EN
  // Latches an abort seen during the train so the current gap ends in FIN.
  logic stop_q, stop_d;
  assign abort_req = abort;
  assign stop_now  = stop_q | abort;
`else
  assign abort_req = 1'b0;
  assign stop_now  = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    rem_d       = rem_q;
    hi_load     = 1'b0;
    hi_load_val = width_q - CNT_W'(1);
    hi_en       = 1'b0;
    lo_load     = 1'b0;
    lo_en       = 1'b0;
`ifdef TTL_PULSE_TX_ABORT_EN
    stop_d      = stop_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          width_d = cmd_width;
          rem_d   = cmd_count;
`ifdef TTL_PULSE_TX_ABORT_EN
          stop_d  = 1'b0;
`endif
          if ((cmd_width != '0) && (cmd_count != '0)) begin
            state_d     = HIGH;
            hi_load     = 1'b1;
            hi_load_val = cmd_width - CNT_W'(1);
          end else begin
            state_d = FIN;
          end
        end
      end
      HIGH: begin
        if (abort_req) begin
          state_d = LOW;
          lo_load = 1'b1;
`ifdef TTL_PULSE_TX_ABORT_EN
          stop_d  = 1'b1;
`endif
        end else if (hi_zero) begin
          state_d = LOW;
          lo_load = 1'b1;
          rem_d   = rem_q - REP_W'(1);
        end else begin
          hi_en = 1'b1;
        end
      end
      LOW: begin
`ifdef TTL_PULSE_TX_ABORT_EN
        if (abort_req) begin
          stop_d = 1'b1;
        end
`endif
        if (lo_zero) begin
          if ((rem_q == '0) || stop_now) begin
            state_d = FIN;
          end else begin
            state_d = HIGH;
            hi_load = 1'b1;
          end
        end else begin
          lo_en = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output is registered so the pin sees exactly the HIGH-state cycles.
    pulse_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      width_q <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
`ifdef TTL_PULSE_TX_ABORT_EN
      stop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      width_q <= width_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
`ifdef TTL_PULSE_TX_ABORT_EN
      stop_q  <= stop_d;
`endif
    end
  end

  ttl_pulse_down_cnt #(
    .W (CNT_W)
  ) u_hi_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (hi_load),
    .load_val (hi_load_val),
    .en       (hi_en),
    .zero     (hi_zero)
  );

  ttl_pulse_down_cnt #(
    .W (GAP_W)
  ) u_lo_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (lo_load),
    .load_val (GAP_LOAD),
    .en       (lo_en),
    .zero     (lo_zero)
  );

  assign pulse_out = pulse_q;
  assign busy      = (state_q == HIGH) || (state_q == LOW) || (state_q == FIN);
  assign done      = (state_q == FIN);

endmodule
